// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying instruction, PC, hazard (dst/Tnew) and
// exception state between stages, with flush-to-bubble and stall-hold.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W        = 32,
    parameter int unsigned       NCH           = 3,
    parameter int unsigned       DST_W         = 5,
    parameter int unsigned       TNEW_W        = 3,
    parameter int unsigned       EXC_W         = 5,
    parameter logic [DATA_W-1:0] RESET_PC      = DATA_W'(32'h0000_3000),
    parameter bit                TNEW_ON_STALL = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     instr_i,
    input  logic [DATA_W-1:0]     pc_i,
    input  logic [DST_W-1:0]      dst_i,
    input  logic [TNEW_W-1:0]     tnew_i,
    input  logic [EXC_W-1:0]      exc_i,
    input  logic [EXC_W-1:0]      exc_local_i,
    input  logic                  bd_i,
    input  logic [NCH*DATA_W-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_W-1:0]     instr_o,
    output logic [DATA_W-1:0]     pc_o,
    output logic [DST_W-1:0]      dst_o,
    output logic [TNEW_W-1:0]     tnew_o,
    output logic [EXC_W-1:0]      exc_o,
    output logic                  bd_o,
    output logic [NCH*DATA_W-1:0] data_o,
    output logic                  fwd_ok_o
);

    // Declaration initialisers give reset values at power-up, before any reset edge.
    logic                  valid_q = 1'b0;
    logic [DATA_W-1:0]     instr_q = '0;
    logic [DATA_W-1:0]     pc_q    = RESET_PC;
    logic [DST_W-1:0]      dst_q   = '0;
    logic [TNEW_W-1:0]     tnew_q  = '0;
    logic [EXC_W-1:0]      exc_q   = '0;
    logic                  bd_q    = 1'b0;
    logic [NCH*DATA_W-1:0] data_q  = '0;

    logic              hold;
    logic              bubble;
    logic [TNEW_W-1:0] tnew_load;
    logic [TNEW_W-1:0] tnew_stall;
    logic [EXC_W-1:0]  exc_load;

    always_comb begin
        hold       = stall_i && !flush_i;
        bubble     = flush_i || (!stall_i && !valid_i);
        tnew_load  = (tnew_i == '0) ? '0 : tnew_i - TNEW_W'(1);
        tnew_stall = (TNEW_ON_STALL && tnew_q != '0) ? tnew_q - TNEW_W'(1) : tnew_q;
        exc_load   = (exc_i != '0) ? exc_i : exc_local_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= RESET_PC;
            dst_q   <= '0;
            tnew_q  <= '0;
            exc_q   <= '0;
            bd_q    <= 1'b0;
            data_q  <= '0;
        end else if (hold) begin
            tnew_q <= tnew_stall;
        end else if (bubble) begin
            // pc/bd still follow upstream so a later exception can derive EPC
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= pc_i;
            dst_q   <= '0;
            tnew_q  <= '0;
            exc_q   <= '0;
            bd_q    <= bd_i;
            data_q  <= '0;
        end else begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
            dst_q   <= dst_i;
            tnew_q  <= tnew_load;
            exc_q   <= exc_load;
            bd_q    <= bd_i;
            data_q  <= data_i;
        end
    end

    assign valid_o  = valid_q;
    assign instr_o  = instr_q;
    assign pc_o     = pc_q;
    assign dst_o    = dst_q;
    assign tnew_o   = tnew_q;
    assign exc_o    = exc_q;
    assign bd_o     = bd_q;
    assign data_o   = data_q;
    assign fwd_ok_o = valid_q && (tnew_q == '0) && (dst_q != '0);

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of each data channel and of instr/pc.
REQ-002 Parameter NCH, default 3: number of data channels carried (e.g. RD, ALURS, WD).
REQ-003 Parameter DST_W, default 5: destination register index width.
REQ-004 Parameter TNEW_W, default 3: Tnew countdown width.
REQ-005 Parameter EXC_W, default 5: exception code width; 0 means no exception.
REQ-006 Parameter RESET_PC, default 32'h0000_3000: PC value on reset.
REQ-007 Parameter TNEW_ON_STALL, default 0: 0 = Tnew held during stall, 1 = Tnew decrements during stall.
REQ-008 clk  input  1  clock; all state updates on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 stall_i  input  1  hold stage contents this cycle.
REQ-011 flush_i  input  1  replace stage contents with a bubble this cycle.
REQ-012 valid_i  input  1  upstream slot holds a real instruction.
REQ-013 instr_i, pc_i  input  DATA_W each  instruction word and its PC.
REQ-014 dst_i  input  DST_W  destination register index.
REQ-015 tnew_i  input  TNEW_W  cycles until result available, as seen at upstream stage.
REQ-016 exc_i  input  EXC_W  exception carried from earlier stages.
REQ-017 exc_local_i  input  EXC_W  exception detected in the upstream stage itself.
REQ-018 bd_i  input  1  instruction is in a branch delay slot.
REQ-019 data_i  input  NCH*DATA_W  packed channel data, channel k at bits [k*DATA_W +: DATA_W].
REQ-020 Outputs valid_o, instr_o, pc_o, dst_o, tnew_o, exc_o, bd_o, data_o: registered counterparts, same widths.
REQ-021 fwd_ok_o  output  1  combinational: valid_o & (tnew_o==0) & (dst_o!=0).

Function
REQ-022 Update priority per edge SHALL be reset > flush_i > stall_i > load.
REQ-023 Load with valid_i=1: every output register SHALL take its input; tnew_o SHALL be tnew_i-1, saturating at 0 (tnew_i=0 gives 0).
REQ-024 Load: exc_o SHALL be exc_i when exc_i!=0, otherwise exc_local_i (earlier exception wins).
REQ-025 Load with valid_i=0: SHALL load a bubble: valid_o=0, instr_o=0, dst_o=0, tnew_o=0, exc_o=0, data_o=0; pc_o=pc_i, bd_o=bd_i.
REQ-026 Flush: SHALL load a bubble as in REQ-025 regardless of valid_i; pc_o/bd_o take pc_i/bd_i so EPC remains derivable.
REQ-027 Stall with TNEW_ON_STALL=0: all outputs SHALL hold.
REQ-028 Stall with TNEW_ON_STALL=1: all outputs hold except tnew_o, which SHALL decrement saturating at 0.
REQ-029 flush_i and stall_i both high: flush SHALL win.
REQ-030 Latency SHALL be exactly one cycle from inputs to outputs; no combinational input-to-output path except through fwd_ok_o's registered inputs.
REQ-031 Channels SHALL be independent; NCH=1 and DATA_W other than 32 SHALL be supported without change.

Reset
REQ-032 On reset: instr_o=0, pc_o=RESET_PC, valid_o=0, dst_o=0, tnew_o=0, exc_o=0, bd_o=0, data_o=0, fwd_ok_o=0.
REQ-033 Reset asserted mid-stall or mid-flush SHALL override both in the same edge.
REQ-034 Registers SHALL also power up to reset values before the first reset edge (simulation initial values).

Verification
REQ-035 Reset then load valid_i=1, pc_i=0x3004, dst_i=8, tnew_i=2 -> next cycle pc_o=0x3004, tnew_o=1, fwd_ok_o=0; reload same with tnew_i=1 -> tnew_o=0, fwd_ok_o=1.
REQ-036 tnew_i=0, dst_i=0, valid_i=1 -> tnew_o=0 (no underflow), fwd_ok_o=0.
REQ-037 Load tnew_i=3, then hold stall_i 2 cycles: TNEW_ON_STALL=0 -> tnew_o stays 2; TNEW_ON_STALL=1 -> 2,1,0.
REQ-038 stall_i=1 and flush_i=1 with valid stage, pc_i=0x3010 -> valid_o=0, instr_o=0, dst_o=0, pc_o=0x3010.
REQ-039 exc_i=0, exc_local_i=4 -> exc_o=4; exc_i=10, exc_local_i=4 -> exc_o=10.
REQ-040 reset asserted while stall_i=1 with loaded contents -> pc_o=RESET_PC, all other outputs 0 on that edge.
